// File: rtl/posit_defines.sv
// Shared posit constants and types for the es=0, n=4 quire datapath.
package posit_defines;

  localparam int FRAC_W  = 4;
  localparam int SCALE_W = 3;
  localparam int QUIRE_W = 19;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/quire_tag_fifo.sv
// Small synchronous FIFO holding requester tags of windows whose eow beat has
// been issued to the quire but whose final result has not yet been returned.
module quire_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign head    = mem[rd_ptr_reg[AW-1:0]];
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Tag storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  // Read/write pointers with a wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/quire_window_arbiter.sv
// Round-robin arbiter sharing one quire between several requester streams.
// Whole windows (sow..eow) are granted; only final results are returned,
// tagged with the index of the requester that owned the window.
module quire_window_arbiter
  import posit_defines::*;
#(
  parameter int NB_REQ    = 4,
  parameter int FRAC_W    = posit_defines::FRAC_W,
  parameter int SCALE_W   = posit_defines::SCALE_W,
  parameter int QUIRE_W   = posit_defines::QUIRE_W,
  parameter int TAG_DEPTH = 4,
  localparam int TAG_W    = $clog2(NB_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NB_REQ-1:0]           req_rts_i,
  output logic [NB_REQ-1:0]           req_rtr_o,
  input  logic [NB_REQ-1:0]           req_sow_i,
  input  logic [NB_REQ-1:0]           req_eow_i,
  input  logic [NB_REQ*FRAC_W-1:0]    req_fraction_i,
  input  logic [NB_REQ*SCALE_W-1:0]   req_scale_i,
  input  logic [NB_REQ-1:0]           req_sign_i,
  input  logic [NB_REQ-1:0]           req_zero_i,
  input  logic [NB_REQ-1:0]           req_NaR_i,
  output logic                        q_rts_o,
  input  logic                        q_rtr_i,
  output logic                        q_sow_o,
  output logic                        q_eow_o,
  output logic                        q_sign_o,
  output logic                        q_zero_o,
  output logic                        q_NaR_o,
  output logic [FRAC_W-1:0]           q_fraction_o,
  output logic [SCALE_W-1:0]          q_scale_o,
  input  logic                        res_rts_i,
  output logic                        res_rtr_o,
  input  logic                        res_eow_i,
  input  logic [QUIRE_W-1:0]          res_data_i,
  input  logic                        res_NaR_i,
  output logic                        out_rts_o,
  input  logic                        out_rtr_i,
  output logic [QUIRE_W-1:0]          out_data_o,
  output logic                        out_NaR_o,
  output logic [TAG_W-1:0]            out_tag_o,
  output logic                        drop_o
);

  arb_state_t       state_reg, state_next;
  logic [TAG_W-1:0] gnt_reg, gnt_next;
  logic [TAG_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [TAG_W:0]   pick;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             eow_block;

  logic [FRAC_W-1:0]  frac_arr  [NB_REQ];
  logic [SCALE_W-1:0] scale_arr [NB_REQ];

  // Unpack the per-requester vector fields so the grant mux is a plain index.
  for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_unpack
    assign frac_arr[gi]  = req_fraction_i[gi*FRAC_W +: FRAC_W];
    assign scale_arr[gi] = req_scale_i[gi*SCALE_W +: SCALE_W];
  end

  // First set bit of cand searching upward from ptr+1 (wrapping); MSB = found.
  function automatic logic [TAG_W:0] rr_pick(input logic [NB_REQ-1:0] cand,
                                             input logic [TAG_W-1:0]  ptr);
    logic             found;
    logic [TAG_W-1:0] idx;
    int               k;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NB_REQ; i++) begin
      k = (int'(ptr) + i) % NB_REQ;
      if (!found && cand[k]) begin
        found = 1'b1;
        idx   = TAG_W'(k);
      end
    end
    return {found, idx};
  endfunction

  assign pick = rr_pick(req_rts_i & req_sow_i, rr_ptr_reg);

  // Beat fields always follow the granted requester; q_rts_o qualifies them.
  assign q_sow_o      = req_sow_i[gnt_reg];
  assign q_eow_o      = req_eow_i[gnt_reg];
  assign q_sign_o     = req_sign_i[gnt_reg];
  assign q_zero_o     = req_zero_i[gnt_reg];
  assign q_NaR_o      = req_NaR_i[gnt_reg];
  assign q_fraction_o = frac_arr[gnt_reg];
  assign q_scale_o    = scale_arr[gnt_reg];

  // Arbiter state, current grant and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      rr_ptr_reg <= TAG_W'(NB_REQ - 1);
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Window grant / forwarding decisions and requester handshakes.
  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    rr_ptr_next = rr_ptr_reg;
    req_rtr_o   = '0;
    q_rts_o     = 1'b0;
    drop_o      = 1'b0;
    push        = 1'b0;
    eow_block   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Beats that do not open a window cannot belong to anything: flush them.
        req_rtr_o = req_rts_i & ~req_sow_i;
        drop_o    = |(req_rts_i & ~req_sow_i);
        if (!fifo_full && pick[TAG_W]) begin
          gnt_next   = pick[TAG_W-1:0];
          state_next = GRANT;
        end
      end
      GRANT: begin
        // Hold the closing beat back if there is no slot to remember its owner.
        eow_block          = req_eow_i[gnt_reg] & fifo_full;
        q_rts_o            = req_rts_i[gnt_reg] & ~eow_block;
        req_rtr_o[gnt_reg] = q_rtr_i & ~eow_block;
        if (q_rts_o && q_rtr_i && req_eow_i[gnt_reg]) begin
          push        = 1'b1;
          rr_ptr_next = gnt_reg;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result side: intermediate results are swallowed, finals are tagged.
  assign res_rtr_o  = res_rts_i & (~res_eow_i | out_rtr_i);
  assign out_rts_o  = res_rts_i & res_eow_i;
  assign out_data_o = res_data_i;
  assign out_NaR_o  = res_NaR_i;
  assign pop        = out_rts_o & out_rtr_i;

  quire_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (gnt_reg),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (out_tag_o)
  );

  // A final result with no outstanding tag means the quire produced a window
  // that was never issued.
  a_no_orphan_result : assert property (@(posedge clk) disable iff (!rst_n)
                                        !(out_rts_o && fifo_empty));

endmodule

// File: tb/tb_quire_window_arbiter.sv
// Directed bench: requester drivers, a 2-stage in-order quire model and
// per-scenario tasks comparing grants and tagged results to hand values.
module tb_quire_window_arbiter;
  localparam int NB_REQ  = 4;
  localparam int FRAC_W  = 4;
  localparam int SCALE_W = 3;
  localparam int QUIRE_W = 19;
  localparam int TAG_W   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NB_REQ-1:0]         req_rts_i = '0, req_rtr_o, req_sow_i = '0, req_eow_i = '0;
  logic [NB_REQ*FRAC_W-1:0]  req_fraction_i = '0;
  logic [NB_REQ*SCALE_W-1:0] req_scale_i = '0;
  logic [NB_REQ-1:0]         req_sign_i = '0, req_zero_i = '0, req_NaR_i = '0;
  logic q_rts_o, q_sow_o, q_eow_o, q_sign_o, q_zero_o, q_NaR_o;
  logic q_rtr_i = 1'b1;
  logic [FRAC_W-1:0]  q_fraction_o;
  logic [SCALE_W-1:0] q_scale_o;
  logic res_rts_i = 1'b0, res_rtr_o, res_eow_i = 1'b0, res_NaR_i = 1'b0;
  logic [QUIRE_W-1:0] res_data_i = '0;
  logic out_rts_o, out_NaR_o, drop_o;
  logic out_rtr_i = 1'b1;
  logic [QUIRE_W-1:0] out_data_o;
  logic [TAG_W-1:0]   out_tag_o;

  always #5 clk = ~clk;

  quire_window_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_rts_i(req_rts_i), .req_rtr_o(req_rtr_o), .req_sow_i(req_sow_i), .req_eow_i(req_eow_i),
    .req_fraction_i(req_fraction_i), .req_scale_i(req_scale_i),
    .req_sign_i(req_sign_i), .req_zero_i(req_zero_i), .req_NaR_i(req_NaR_i),
    .q_rts_o(q_rts_o), .q_rtr_i(q_rtr_i), .q_sow_o(q_sow_o), .q_eow_o(q_eow_o),
    .q_sign_o(q_sign_o), .q_zero_o(q_zero_o), .q_NaR_o(q_NaR_o),
    .q_fraction_o(q_fraction_o), .q_scale_o(q_scale_o),
    .res_rts_i(res_rts_i), .res_rtr_o(res_rtr_o), .res_eow_i(res_eow_i),
    .res_data_i(res_data_i), .res_NaR_i(res_NaR_i),
    .out_rts_o(out_rts_o), .out_rtr_i(out_rtr_i), .out_data_o(out_data_o),
    .out_NaR_o(out_NaR_o), .out_tag_o(out_tag_o), .drop_o(drop_o)
  );

  typedef struct packed {
    logic sow; logic eow; logic sign; logic zero; logic nar;
    logic [FRAC_W-1:0] frac; logic [SCALE_W-1:0] scale;
  } beat_t;
  typedef struct packed {
    logic eow; logic [QUIRE_W-1:0] data; logic nar; int ready;
  } res_t;
  typedef struct packed {
    logic [TAG_W-1:0] tag; logic [QUIRE_W-1:0] data; logic nar;
  } out_t;

  beat_t rq [NB_REQ][$];
  res_t  resq[$];
  out_t  outs[$];
  int    grants[$];
  int    drops = 0, xfers = 0, cyc = 0;
  int    total = 0, bad = 0;
  logic [QUIRE_W-1:0] acc = '0;
  logic               nar_acc = 1'b0;

  // Quire value model: 1.f * 2^scale in units of 2^-8.
  function automatic logic [QUIRE_W-1:0] contrib(input logic zero, input logic sign,
                                                 input logic [FRAC_W-1:0] f,
                                                 input logic [SCALE_W-1:0] s);
    int mag;
    if (zero) return '0;
    mag = (16 + int'(f)) << (int'($signed(s)) + 4);
    return sign ? QUIRE_W'(-mag) : QUIRE_W'(mag);
  endfunction

  function automatic beat_t mk(input logic sow, input logic eow, input logic zero,
                               input logic [FRAC_W-1:0] f, input logic [SCALE_W-1:0] s);
    beat_t b;
    b = '0;
    b.sow = sow; b.eow = eow; b.zero = zero; b.frac = f; b.scale = s;
    return b;
  endfunction

  // Present requester heads and the quire result head away from the clock edge.
  always @(negedge clk) begin
    beat_t b;
    for (int i = 0; i < NB_REQ; i++) begin
      b = (rq[i].size() > 0) ? rq[i][0] : '0;
      req_rts_i[i] = (rq[i].size() > 0);
      req_sow_i[i] = b.sow;
      req_eow_i[i] = b.eow;
      req_sign_i[i] = b.sign;
      req_zero_i[i] = b.zero;
      req_NaR_i[i] = b.nar;
      req_fraction_i[i*FRAC_W +: FRAC_W] = b.frac;
      req_scale_i[i*SCALE_W +: SCALE_W] = b.scale;
    end
    if (resq.size() > 0 && resq[0].ready <= cyc) begin
      res_rts_i = 1'b1; res_eow_i = resq[0].eow;
      res_data_i = resq[0].data; res_NaR_i = resq[0].nar;
    end else begin
      res_rts_i = 1'b0; res_eow_i = 1'b0; res_data_i = '0; res_NaR_i = 1'b0;
    end
  end

  // Observe handshakes at the edge: pop requester beats, run the quire, log outputs.
  always @(posedge clk) begin
    if (!rst_n) begin
      resq.delete();
      acc = '0;
      nar_acc = 1'b0;
    end else begin
      cyc++;
      for (int i = 0; i < NB_REQ; i++)
        if (req_rts_i[i] && req_rtr_o[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (res_rts_i && res_rtr_o) void'(resq.pop_front());
      if (q_rts_o && q_rtr_i) begin
        xfers++;
        if (q_sow_o)
          for (int i = 0; i < NB_REQ; i++) if (req_rtr_o[i]) grants.push_back(i);
        acc = (q_sow_o ? '0 : acc) + contrib(q_zero_o, q_sign_o, q_fraction_o, q_scale_o);
        nar_acc = (q_sow_o ? 1'b0 : nar_acc) | q_NaR_o;
        resq.push_back('{eow: q_eow_o, data: acc, nar: nar_acc, ready: cyc + 2});
      end
      if (out_rts_o && out_rtr_i)
        outs.push_back('{tag: out_tag_o, data: out_data_o, nar: out_NaR_o});
      if (drop_o) drops++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs;
    outs.delete(); grants.delete(); drops = 0; xfers = 0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    for (int i = 0; i < NB_REQ; i++) rq[i].delete();
    tick(2);
    rst_n = 1'b1;
    clear_logs();
    tick(1);
  endtask

  // Bounded wait for n delivered results; callers compare the count afterwards.
  task automatic wait_outs(input int n);
    int k;
    k = 0;
    while (outs.size() < n && k < 400) begin tick(1); k++; end
    tick(6);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2); #1;
    total++; if (req_rtr_o !== '0) begin bad++; $display("FAIL reset_rtr got=%b want=0", req_rtr_o); end
    total++; if (q_rts_o !== 1'b0) begin bad++; $display("FAIL reset_q_rts got=%b want=0", q_rts_o); end
    total++; if (drop_o !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b want=0", drop_o); end
    total++; if ({res_rtr_o, out_rts_o} !== 2'b00) begin bad++; $display("FAIL reset_res got=%b want=00", {res_rtr_o, out_rts_o}); end
    $display("reset: rtr=%b q_rts=%b drop=%b", req_rtr_o, q_rts_o, drop_o);
  endtask

  task automatic test_single;
    do_reset();
    rq[0].push_back(mk(1, 0, 0, 0, 0));
    rq[0].push_back(mk(0, 0, 0, 0, 0));
    rq[0].push_back(mk(0, 1, 0, 0, 0));
    wait_outs(1);
    total++; if (outs.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", outs.size()); end
    if (outs.size() >= 1) begin
      total++; if (outs[0].tag !== 2'd0) begin bad++; $display("FAIL single_tag got=%0d want=0", outs[0].tag); end
      total++; if (outs[0].data !== 19'd768) begin bad++; $display("FAIL single_data got=%0d want=768", outs[0].data); end
      $display("single: tag=%0d data=%0d", outs[0].tag, outs[0].data);
    end
    total++; if (drops != 0) begin bad++; $display("FAIL single_drop got=%0d want=0", drops); end
  endtask

  task automatic test_all_four;
    do_reset();
    for (int i = 0; i < NB_REQ; i++) begin
      rq[i].push_back(mk(1, 0, 0, FRAC_W'(i), 3'd0));
      rq[i].push_back(mk(0, 1, 0, 0, 3'd1));
    end
    wait_outs(4);
    total++; if (outs.size() != 4) begin bad++; $display("FAIL all4_count got=%0d want=4", outs.size()); end
    for (int i = 0; i < 4; i++) begin
      if (grants.size() > i) begin
        total++; if (grants[i] != i) begin bad++; $display("FAIL all4_grant[%0d] got=%0d want=%0d", i, grants[i], i); end
      end
      if (outs.size() > i) begin
        total++; if (outs[i].tag !== TAG_W'(i)) begin bad++; $display("FAIL all4_tag[%0d] got=%0d want=%0d", i, outs[i].tag, i); end
        total++; if (outs[i].data !== QUIRE_W'(768 + 16*i)) begin bad++; $display("FAIL all4_data[%0d] got=%0d want=%0d", i, outs[i].data, 768 + 16*i); end
        $display("all4: result %0d tag=%0d data=%0d", i, outs[i].tag, outs[i].data);
      end
    end
  endtask

  task automatic test_fairness;
    int exp_g [3] = '{1, 3, 1};
    int exp_d [3] = '{512, 768, 512};
    do_reset();
    for (int w = 0; w < 2; w++) begin
      rq[1].push_back(mk(1, 0, 0, 0, 0));
      rq[1].push_back(mk(0, 1, 0, 0, 0));
    end
    rq[3].push_back(mk(1, 0, 0, 0, 3'd0));
    rq[3].push_back(mk(0, 1, 0, 0, 3'd1));
    wait_outs(3);
    total++; if (grants.size() != 3) begin bad++; $display("FAIL fair_grants got=%0d want=3", grants.size()); end
    for (int i = 0; i < 3; i++) begin
      if (grants.size() > i) begin
        total++; if (grants[i] != exp_g[i]) begin bad++; $display("FAIL fair_grant[%0d] got=%0d want=%0d", i, grants[i], exp_g[i]); end
      end
      if (outs.size() > i) begin
        total++; if (outs[i].tag !== TAG_W'(exp_g[i]) || outs[i].data !== QUIRE_W'(exp_d[i])) begin
          bad++; $display("FAIL fair_out[%0d] got=%0d/%0d want=%0d/%0d", i, outs[i].tag, outs[i].data, exp_g[i], exp_d[i]);
        end
        $display("fair: result %0d tag=%0d data=%0d", i, outs[i].tag, outs[i].data);
      end
    end
  endtask

  task automatic test_back_pressure;
    int exp_t [6] = '{0, 1, 2, 3, 0, 1};
    int exp_d [6] = '{512, 528, 544, 560, 528, 544};
    do_reset();
    out_rtr_i = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      for (int k = 0; k < ((i < 2) ? 2 : 1); k++) begin
        rq[i].push_back(mk(1, 0, 0, FRAC_W'(k), 3'd0));
        rq[i].push_back(mk(0, 1, 0, FRAC_W'(i), 3'd0));
      end
    end
    tick(20);
    total++; if (grants.size() != 4) begin bad++; $display("FAIL bp_stall_grants got=%0d want=4", grants.size()); end
    total++; if (outs.size() != 0) begin bad++; $display("FAIL bp_stall_outs got=%0d want=0", outs.size()); end
    $display("bp: stalled with grants=%0d outs=%0d", grants.size(), outs.size());
    out_rtr_i = 1'b1;
    wait_outs(6);
    total++; if (outs.size() != 6) begin bad++; $display("FAIL bp_count got=%0d want=6", outs.size()); end
    for (int i = 0; i < 6; i++) begin
      if (outs.size() > i) begin
        total++; if (outs[i].tag !== TAG_W'(exp_t[i]) || outs[i].data !== QUIRE_W'(exp_d[i])) begin
          bad++; $display("FAIL bp_out[%0d] got=%0d/%0d want=%0d/%0d", i, outs[i].tag, outs[i].data, exp_t[i], exp_d[i]);
        end
        $display("bp: result %0d tag=%0d data=%0d", i, outs[i].tag, outs[i].data);
      end
    end
  endtask

  task automatic test_single_beat_and_drop;
    do_reset();
    rq[2].push_back(mk(1, 1, 1, 4'd5, 3'd2));
    wait_outs(1);
    total++; if (outs.size() != 1) begin bad++; $display("FAIL sb_count got=%0d want=1", outs.size()); end
    if (outs.size() >= 1) begin
      total++; if (outs[0].tag !== 2'd2 || outs[0].data !== '0) begin
        bad++; $display("FAIL sb_out got=%0d/%0d want=2/0", outs[0].tag, outs[0].data);
      end
      $display("single-beat: tag=%0d data=%0d", outs[0].tag, outs[0].data);
    end
    total++; if (drops != 0) begin bad++; $display("FAIL sb_nodrop got=%0d want=0", drops); end
    rq[1].push_back(mk(0, 0, 0, 4'd3, 3'd0));
    tick(5);
    total++; if (drops != 1) begin bad++; $display("FAIL drop_cycles got=%0d want=1", drops); end
    total++; if (rq[1].size() != 0) begin bad++; $display("FAIL drop_consumed got=%0d want=0", rq[1].size()); end
    total++; if (grants.size() != 1) begin bad++; $display("FAIL drop_nogrant got=%0d want=1", grants.size()); end
    $display("drop: cycles=%0d grants=%0d", drops, grants.size());
  endtask

  task automatic test_reset_mid_window;
    int k;
    do_reset();
    rq[0].push_back(mk(1, 1, 0, 0, 0));
    wait_outs(1);
    rq[1].push_back(mk(1, 0, 0, 0, 0));
    rq[1].push_back(mk(0, 0, 0, 0, 0));
    rq[1].push_back(mk(0, 1, 0, 0, 0));
    k = 0;
    while (xfers < 3 && k < 100) begin tick(1); k++; end
    total++; if (xfers < 3) begin bad++; $display("FAIL rst_mid_reach got=%0d want=3", xfers); end
    rst_n = 1'b0;
    for (int i = 0; i < NB_REQ; i++) rq[i].delete();
    tick(1); #1;
    total++; if (req_rtr_o !== '0) begin bad++; $display("FAIL rst_mid_rtr got=%b want=0", req_rtr_o); end
    total++; if (q_rts_o !== 1'b0) begin bad++; $display("FAIL rst_mid_q_rts got=%b want=0", q_rts_o); end
    tick(1);
    rst_n = 1'b1;
    clear_logs();
    tick(1);
    rq[0].push_back(mk(1, 1, 0, 0, 3'd0));
    rq[2].push_back(mk(1, 1, 0, 0, 3'd1));
    wait_outs(2);
    total++; if (grants.size() < 1 || grants[0] != 0) begin
      bad++; $display("FAIL rst_mid_first got=%0d want=0", (grants.size() > 0) ? grants[0] : -1);
    end
    total++; if (outs.size() != 2) begin bad++; $display("FAIL rst_mid_count got=%0d want=2", outs.size()); end
    if (outs.size() >= 2) begin
      total++; if (outs[0].tag !== 2'd0 || outs[0].data !== 19'd256 || outs[1].tag !== 2'd2 || outs[1].data !== 19'd512) begin
        bad++; $display("FAIL rst_mid_outs got=%0d/%0d,%0d/%0d want=0/256,2/512",
                        outs[0].tag, outs[0].data, outs[1].tag, outs[1].data);
      end
      $display("rst-mid: results %0d/%0d %0d/%0d", outs[0].tag, outs[0].data, outs[1].tag, outs[1].data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_back_pressure();
    test_single_beat_and_drop();
    test_reset_mid_window();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
